ddr2_controller_ex_lfsr8_checker: RTL and testbench

Read-side companion to the example driver's 8-bit LFSR pattern generator. It regenerates the expected LFSR sequence and compares it beat-by-beat against read data returned from the DDR2 controller. It flags mismatches, counts them, captures the first failing beat and reports lock status. It works in seeded mode, where it starts from the same seed as the writer, or in self-synchronising mode, where it locks onto the incoming stream.

---
 rtl/ddr2_controller_ex_lfsr8_checker_pkg.sv | 8 +
 rtl/ddr2_controller_ex_lfsr8_checker_if.sv | 24 ++
 rtl/ddr2_controller_ex_err_capture.sv | 43 ++++
 rtl/ddr2_controller_ex_lfsr8_checker.sv | 94 +++++++++
 tb/tb_ddr2_controller_ex_lfsr8_checker.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/ddr2_controller_ex_lfsr8_checker_pkg.sv
// ddr2_controller_ex_lfsr8_checker_pkg: LFSR step shared with the pattern generator, checker state type
package ddr2_controller_ex_lfsr8_checker_pkg;
    localparam int LFSR_W = 8;
    typedef enum logic [1:0] {IDLE, SYNC, CHECK} chk_state_e;
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
        return {x[6], x[5], x[4], x[3] ^ x[7], x[2] ^ x[7], x[1] ^ x[7], x[0], x[7]};
    endfunction
endpackage

// File: rtl/ddr2_controller_ex_lfsr8_checker_if.sv
// ddr2_controller_ex_lfsr8_checker_if: read-beat stream, controls and status of the LFSR checker
interface ddr2_controller_ex_lfsr8_checker_if #(parameter int ERR_CNT_W = 16);
    import ddr2_controller_ex_lfsr8_checker_pkg::*;
    logic                 enable;
    logic                 sync_mode;
    logic                 rdata_valid;
    logic [LFSR_W-1:0]    rdata;
    logic                 clear_errors;
    logic [LFSR_W-1:0]    expected;
    logic                 locked;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 first_err_valid;
    logic [LFSR_W-1:0]    first_err_data;
    logic [LFSR_W-1:0]    first_err_exp;
    modport master (
        output enable, sync_mode, rdata_valid, rdata, clear_errors,
        input  expected, locked, err, err_count, first_err_valid, first_err_data, first_err_exp
    );
    modport slave (
        input  enable, sync_mode, rdata_valid, rdata, clear_errors,
        output expected, locked, err, err_count, first_err_valid, first_err_data, first_err_exp
    );
endinterface

// File: rtl/ddr2_controller_ex_err_capture.sv
// ddr2_controller_ex_err_capture: saturating mismatch counter, err pulse and first-error latch
module ddr2_controller_ex_err_capture
    import ddr2_controller_ex_lfsr8_checker_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 mis,
    input  logic [LFSR_W-1:0]    rdata,
    input  logic [LFSR_W-1:0]    expected,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_err_valid,
    output logic [LFSR_W-1:0]    first_err_data,
    output logic [LFSR_W-1:0]    first_err_exp
);
    logic [ERR_CNT_W-1:0] cnt_base;
    logic                 fv_base;
    // clear is applied first so a same-cycle mismatch restarts the count and capture
    always_comb begin
        cnt_base = clear ? '0 : err_count;
        fv_base  = clear ? 1'b0 : first_err_valid;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            err             <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_data  <= '0;
            first_err_exp   <= '0;
        end else begin
            err             <= mis;
            err_count       <= (mis && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
            first_err_valid <= fv_base | mis;
            if (mis && !fv_base) begin
                first_err_data <= rdata;
                first_err_exp  <= expected;
            end
        end
    end
endmodule

// File: rtl/ddr2_controller_ex_lfsr8_checker.sv
// ddr2_controller_ex_lfsr8_checker: regenerates the 8-bit LFSR stream and checks read beats against it
module ddr2_controller_ex_lfsr8_checker
    import ddr2_controller_ex_lfsr8_checker_pkg::*;
#(
    parameter logic [31:0] SEED       = 32'd32,
    parameter int          LOCK_COUNT = 4,
    parameter int          ERR_CNT_W  = 16
) (
    input logic clk,
    input logic reset,
    ddr2_controller_ex_lfsr8_checker_if.slave bus
);
    localparam logic [LFSR_W-1:0] SEED8 = SEED[LFSR_W-1:0];
    localparam logic [3:0]        LC    = 4'(LOCK_COUNT);
    chk_state_e        state, state_d;
    logic [LFSR_W-1:0] expected, exp_d;
    logic [3:0]        run, run_d, miss, miss_d;
    logic              primed, primed_d, sync_lat, sync_d, hit, mis;
    assign hit = bus.rdata == expected;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            expected <= SEED8;
            run      <= '0;
            miss     <= '0;
            primed   <= 1'b0;
            sync_lat <= 1'b0;
        end else begin
            state    <= state_d;
            expected <= exp_d;
            run      <= run_d;
            miss     <= miss_d;
            primed   <= primed_d;
            sync_lat <= sync_d;
        end
    end
    // primed marks that expected was derived from the stream, so the first SYNC beat never matches
    always_comb begin
        state_d  = state;
        exp_d    = expected;
        run_d    = run;
        miss_d   = miss;
        primed_d = primed;
        sync_d   = sync_lat;
        mis      = 1'b0;
        if (!bus.enable) begin
            state_d  = IDLE;
            exp_d    = SEED8;
            run_d    = '0;
            miss_d   = '0;
            primed_d = 1'b0;
        end else if (state == SYNC) begin
            if (bus.rdata_valid) begin
                exp_d    = lfsr_step(bus.rdata);
                primed_d = 1'b1;
                run_d    = (primed && hit) ? run + 4'd1 : 4'd0;
                if (primed && hit && run + 4'd1 == LC) begin
                    state_d = CHECK;
                    miss_d  = '0;
                end
            end
        end else if (state == CHECK) begin
            if (bus.rdata_valid) begin
                exp_d  = lfsr_step(expected);
                mis    = !hit;
                miss_d = hit ? 4'd0 : (miss == 4'hF ? miss : miss + 4'd1);
                if (sync_lat && !hit && miss + 4'd1 == LC) begin
                    state_d  = SYNC;
                    run_d    = '0;
                    miss_d   = '0;
                    primed_d = 1'b0;
                end
            end
        end else begin
            state_d = bus.sync_mode ? SYNC : CHECK;
            sync_d  = bus.sync_mode;
        end
    end
    assign bus.expected = expected;
    assign bus.locked   = state == CHECK;
    ddr2_controller_ex_err_capture #(.ERR_CNT_W(ERR_CNT_W)) u_cap (
        .clk             (clk),
        .reset           (reset),
        .clear           (bus.clear_errors),
        .mis             (mis),
        .rdata           (bus.rdata),
        .expected        (expected),
        .err             (bus.err),
        .err_count       (bus.err_count),
        .first_err_valid (bus.first_err_valid),
        .first_err_data  (bus.first_err_data),
        .first_err_exp   (bus.first_err_exp)
    );
endmodule

// File: tb/tb_ddr2_controller_ex_lfsr8_checker.sv
// tb_ddr2_controller_ex_lfsr8_checker: directed checks of seeded, self-sync, saturation and clear behaviour
module tb_ddr2_controller_ex_lfsr8_checker;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    always #5 clk = ~clk;
    ddr2_controller_ex_lfsr8_checker_if #(.ERR_CNT_W(16)) bus ();
    ddr2_controller_ex_lfsr8_checker_if #(.ERR_CNT_W(2))  bus2 ();
    ddr2_controller_ex_lfsr8_checker #(.SEED(32'd32), .LOCK_COUNT(4), .ERR_CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    ddr2_controller_ex_lfsr8_checker #(.SEED(32'd32), .LOCK_COUNT(4), .ERR_CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );
    // hand-derived LFSR stream from seed 0x20
    logic [7:0] pat [0:17] = '{8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87,
                               8'h13, 8'h26, 8'h4C, 8'h98, 8'h2D, 8'h5A, 8'hB4, 8'h75, 8'hEA};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic beat(input logic [7:0] d, input logic clr = 1'b0);
        @(negedge clk);
        bus.rdata_valid = 1'b1;
        bus.rdata = d;
        bus.clear_errors = clr;
        step();
    endtask
    task automatic beat2(input logic [7:0] d, input logic clr = 1'b0);
        @(negedge clk);
        bus2.rdata_valid = 1'b1;
        bus2.rdata = d;
        bus2.clear_errors = clr;
        step();
    endtask
    task automatic en(input logic e, input logic sm);
        @(negedge clk);
        bus.enable = e;
        bus.sync_mode = sm;
        bus.rdata_valid = 1'b0;
        bus.clear_errors = 1'b0;
        step();
    endtask
    initial begin
        logic [7:0] gexp [0:4];
        reset = 1'b1;
        {bus.enable, bus.sync_mode, bus.rdata_valid, bus.clear_errors, bus.rdata} = '0;
        {bus2.enable, bus2.sync_mode, bus2.rdata_valid, bus2.clear_errors, bus2.rdata} = '0;
        repeat (3) step();
        check("rst_expected", bus.expected, 32'h20);
        check("rst_locked", bus.locked, 0);
        check("rst_err", bus.err, 0);
        check("rst_count", bus.err_count, 0);
        check("rst_fev", bus.first_err_valid, 0);
        check("rst_fed", bus.first_err_data, 0);
        check("rst_fex", bus.first_err_exp, 0);
        @(negedge clk);
        reset = 1'b0;
        // seeded clean stream
        en(1, 0);
        check("seed_locked", bus.locked, 1);
        for (int i = 0; i < 5; i++) begin
            beat(pat[i]);
            check($sformatf("seed_err%0d", i), bus.err, 0);
        end
        check("seed_expected", bus.expected, 32'h74);
        check("seed_count", bus.err_count, 0);
        // seeded stream with third beat corrupted
        en(0, 0);
        check("drop_expected", bus.expected, 32'h20);
        check("drop_locked", bus.locked, 0);
        en(1, 0);
        for (int i = 0; i < 5; i++) begin
            beat(i == 2 ? 8'h81 : pat[i]);
            check($sformatf("corr_err%0d", i), bus.err, i == 2);
            if (i == 2) begin
                check("corr_count", bus.err_count, 1);
                check("corr_fev", bus.first_err_valid, 1);
                check("corr_fed", bus.first_err_data, 32'h81);
                check("corr_fex", bus.first_err_exp, 32'h80);
            end
        end
        check("corr_count_end", bus.err_count, 1);
        check("corr_expected", bus.expected, 32'h74);
        // enable drop keeps errors; clear_errors then zeroes them
        en(0, 0);
        check("keep_count", bus.err_count, 1);
        check("keep_expected", bus.expected, 32'h20);
        @(negedge clk);
        bus.clear_errors = 1'b1;
        step();
        check("clr_count", bus.err_count, 0);
        check("clr_fev", bus.first_err_valid, 0);
        // self-sync lock onto a stream starting at 0x1D
        en(1, 1);
        check("sync_locked0", bus.locked, 0);
        for (int i = 3; i <= 7; i++) begin
            beat(pat[i]);
            check($sformatf("sync_lock%0d", i), bus.locked, i == 7);
            check($sformatf("sync_err%0d", i), bus.err, 0);
        end
        check("sync_expected", bus.expected, 32'h87);
        // four garbage beats lose lock
        for (int i = 8; i <= 11; i++) begin
            beat(8'h00);
            check($sformatf("loss_err%0d", i), bus.err, 1);
            check($sformatf("loss_lock%0d", i), bus.locked, i != 11);
        end
        check("loss_count", bus.err_count, 4);
        check("loss_fed", bus.first_err_data, 32'h00);
        check("loss_fex", bus.first_err_exp, 32'h87);
        // relock after five good beats, no errors counted while syncing
        for (int i = 12; i <= 16; i++) begin
            beat(pat[i]);
            check($sformatf("relock%0d", i), bus.locked, i == 16);
            check($sformatf("relock_err%0d", i), bus.err, 0);
        end
        check("relock_expected", bus.expected, 32'hEA);
        check("relock_count", bus.err_count, 4);
        // reset mid-stream overrides a valid beat
        @(negedge clk);
        reset = 1'b1;
        bus.rdata_valid = 1'b1;
        bus.rdata = 8'h00;
        step();
        check("mrst_expected", bus.expected, 32'h20);
        check("mrst_locked", bus.locked, 0);
        check("mrst_count", bus.err_count, 0);
        check("mrst_fev", bus.first_err_valid, 0);
        check("mrst_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.rdata_valid = 1'b0;
        bus.enable = 1'b0;
        // 2-bit counter saturation, then clear together with a mismatch
        @(negedge clk);
        bus2.enable = 1'b1;
        step();
        gexp = '{8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
        for (int i = 0; i < 5; i++) begin
            beat2(8'h00);
            check($sformatf("sat_err%0d", i), bus2.err, 1);
            check($sformatf("sat_count%0d", i), bus2.err_count, i < 3 ? i + 1 : 3);
        end
        check("sat_fed", bus2.first_err_data, 32'h00);
        check("sat_fex", bus2.first_err_exp, {24'h0, gexp[0]});
        beat2(8'hFF, 1'b1);
        check("clrmis_err", bus2.err, 1);
        check("clrmis_count", bus2.err_count, 1);
        check("clrmis_fev", bus2.first_err_valid, 1);
        check("clrmis_fed", bus2.first_err_data, 32'hFF);
        check("clrmis_fex", bus2.first_err_exp, 32'h74);
        @(negedge clk);
        bus2.rdata_valid = 1'b0;
        bus2.clear_errors = 1'b0;
        step();
        check("clrmis_err_off", bus2.err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
